// File: rtl/qspi_io_shifter.sv
// qspi_io_shifter
//   Moves data words between a QSPI host (mode 0, quad lanes) and the local
//   clock domain. The host's SCK, CE and data lanes are oversampled on clk_i
//   through SYNC_STAGES flops. Receive words are shifted in MSB-first on SCK
//   rising edges. Transmit words are driven a nibble at a time: the first
//   nibble when the word's configuration is sampled, and each later nibble on
//   an SCK falling edge.
//
// Ports
//   clk_i       system clock; everything runs on its rising edge
//   reset_ni    asynchronous active-low reset
//   sck_i       QSPI serial clock (mode 0, idles low)
//   ce_ni       QSPI chip enable, active low
//   io_i[3:0]   data lanes from the pads
//   io_o[3:0]   data lanes to the pads (0 whenever io_oe_o is low)
//   io_oe_o     pad output enable
//   txnbc_i     bit count of the current word (0 means 4)
//   txndir_i    0 = receive from host, 1 = transmit to host
//   txndata_i   word to transmit
//   txndata_o   last fully received word, zero-extended
//   txndone_o   one-cycle pulse when a word completes
//   txnreset_o  high while CE is deasserted (synchronized)
module qspi_io_shifter #(
  parameter int IOREG_BITS       = 32,
  parameter int CYCLE_COUNT_BITS = 8,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        sck_i,
  input  logic                        ce_ni,
  input  logic [3:0]                  io_i,
  output logic [3:0]                  io_o,
  output logic                        io_oe_o,
  input  logic [CYCLE_COUNT_BITS-1:0] txnbc_i,
  input  logic                        txndir_i,
  input  logic [IOREG_BITS-1:0]       txndata_i,
  output logic [IOREG_BITS-1:0]       txndata_o,
  output logic                        txndone_o,
  output logic                        txnreset_o
);

  localparam int CB = CYCLE_COUNT_BITS;
  localparam logic [CB-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, RX, TX} state_t;

  // Synchronizers; the last stage of each feeds the logic below.
  logic [SYNC_STAGES-1:0]      sck_sync_reg;
  logic [SYNC_STAGES-1:0]      ce_sync_reg;
  logic [SYNC_STAGES-1:0][3:0] io_sync_reg;
  logic                        sck_prev_reg, ce_prev_reg;

  state_t                state_reg, state_next;
  logic                  oe_reg, oe_next;
  logic [3:0]            io_reg, io_next;
  logic                  done_reg, done_next;
  logic [IOREG_BITS-1:0] data_reg, data_next;
  logic [IOREG_BITS-1:0] shreg_reg, shreg_next;
  logic [IOREG_BITS-1:0] tx_word_reg, tx_word_next;
  logic [CB-1:0]         rem_reg, rem_next;   // nibbles still to be consumed
  logic                  pend_reg, pend_next; // word done, waiting for next config sample

  logic sck_s, ce_s;
  logic [3:0] io_s;
  logic sck_rise, sck_fall, ce_fall;

  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign ce_s     = ce_sync_reg[SYNC_STAGES-1];
  assign io_s     = io_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s & sck_prev_reg;
  assign ce_fall  = ~ce_s & ce_prev_reg;

  // Nibble at position pos (0 = least significant) of a word; positions past
  // the top of the word shift out to zero.
  function automatic logic [3:0] nib_at(input logic [IOREG_BITS-1:0] word,
                                        input logic [CB-1:0] pos);
    logic [IOREG_BITS-1:0] shifted;
    shifted = word >> {pos, 2'b00};
    return shifted[3:0];
  endfunction

  // Configuration presented for a new word.
  logic [CB:0]   bc_plus3;
  logic [CB-1:0] start_nibs;
  logic [3:0]    start_tx_nib;
  logic [IOREG_BITS-1:0] rx_shifted;

  assign bc_plus3     = {1'b0, txnbc_i} + (CB+1)'(3);
  assign start_nibs   = (txnbc_i == '0) ? ONE : {1'b0, bc_plus3[CB:2]};
  assign start_tx_nib = nib_at(txndata_i, start_nibs - ONE);
  assign rx_shifted   = {shreg_reg[IOREG_BITS-5:0], io_s};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sck_sync_reg <= '0;
      ce_sync_reg  <= '1;
      io_sync_reg  <= '0;
      sck_prev_reg <= 1'b0;
      ce_prev_reg  <= 1'b1;
    end else begin
      sck_sync_reg <= {sck_sync_reg, sck_i};
      ce_sync_reg  <= {ce_sync_reg, ce_ni};
      for (int i = SYNC_STAGES - 1; i > 0; i--) io_sync_reg[i] <= io_sync_reg[i-1];
      io_sync_reg[0] <= io_i;
      sck_prev_reg <= sck_s;
      ce_prev_reg  <= ce_s;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg   <= IDLE;
      oe_reg      <= 1'b0;
      io_reg      <= '0;
      done_reg    <= 1'b0;
      data_reg    <= '0;
      shreg_reg   <= '0;
      tx_word_reg <= '0;
      rem_reg     <= '0;
      pend_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      oe_reg      <= oe_next;
      io_reg      <= io_next;
      done_reg    <= done_next;
      data_reg    <= data_next;
      shreg_reg   <= shreg_next;
      tx_word_reg <= tx_word_next;
      rem_reg     <= rem_next;
      pend_reg    <= pend_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    oe_next      = oe_reg;
    io_next      = io_reg;
    done_next    = 1'b0;
    data_next    = data_reg;
    shreg_next   = shreg_reg;
    tx_word_next = tx_word_reg;
    rem_next     = rem_reg;
    pend_next    = pend_reg;

    // Deasserted CE overrides everything, including an edge that would start
    // or complete a word in the same cycle.
    if (ce_s) begin
      state_next = IDLE;
      oe_next    = 1'b0;
      io_next    = '0;
      pend_next  = 1'b0;
    end else if ((state_reg == IDLE && ce_fall) ||
                 (state_reg != IDLE && pend_reg && sck_fall)) begin
      // Config sample point: start a new word.
      rem_next     = start_nibs;
      pend_next    = 1'b0;
      shreg_next   = '0;
      tx_word_next = txndata_i;
      if (txndir_i) begin
        state_next = TX;
        oe_next    = 1'b1;
        io_next    = start_tx_nib;
      end else begin
        state_next = RX;
        oe_next    = 1'b0;
        io_next    = '0;
      end
    end else if (state_reg != IDLE && !pend_reg) begin
      if (sck_rise) begin
        rem_next = rem_reg - ONE;
        if (state_reg == RX) shreg_next = rx_shifted;
        if (rem_reg == ONE) begin
          done_next = 1'b1;
          pend_next = 1'b1;
          if (state_reg == RX) data_next = rx_shifted;
        end
      end else if (sck_fall && state_reg == TX) begin
        // rem_reg already counts the nibble just consumed, so rem-1 is the
        // position of the next one.
        io_next = nib_at(tx_word_reg, rem_reg - ONE);
      end
    end
  end

  assign io_o       = io_reg & {4{oe_reg}};
  assign io_oe_o    = oe_reg;
  assign txndata_o  = data_reg;
  assign txndone_o  = done_reg;
  assign txnreset_o = ce_s;

endmodule

// File: tb/tb_qspi_io_shifter.sv
// Directed bench for qspi_io_shifter: drives a mode-0 QSPI host with SCK at
// clk/16 and checks received words, transmitted nibbles, output enable,
// done pulses, aborts and reset behaviour.
module tb_qspi_io_shifter;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        sck_i = 1'b0;
  logic        ce_ni = 1'b1;
  logic [3:0]  io_i = '0;
  logic [3:0]  io_o;
  logic        io_oe_o;
  logic [7:0]  txnbc_i = '0;
  logic        txndir_i = 1'b0;
  logic [31:0] txndata_i = '0;
  logic [31:0] txndata_o;
  logic        txndone_o;
  logic        txnreset_o;

  qspi_io_shifter dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .sck_i      (sck_i),
    .ce_ni      (ce_ni),
    .io_i       (io_i),
    .io_o       (io_o),
    .io_oe_o    (io_oe_o),
    .txnbc_i    (txnbc_i),
    .txndir_i   (txndir_i),
    .txndata_i  (txndata_i),
    .txndata_o  (txndata_o),
    .txndone_o  (txndone_o),
    .txnreset_o (txnreset_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Monitor: done pulses, over-long pulses, cycles with output enable high.
  int   done_cnt = 0;
  int   wide_cnt = 0;
  int   oe_hi_cnt = 0;
  logic done_prev = 1'b0;
  always @(negedge clk_i) begin
    if (txndone_o) done_cnt++;
    if (txndone_o && done_prev) wide_cnt++;
    done_prev = txndone_o;
    if (io_oe_o) oe_hi_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic waitn(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Each nibble task lowers SCK first, so config for the next word can be
  // set between tasks (before the falling edge that samples it).
  task automatic rx_nib(input logic [3:0] v);
    sck_i = 1'b0;
    io_i  = v;
    waitn(8);
    sck_i = 1'b1;
    waitn(8);
  endtask

  task automatic tx_nib(input string tag, input logic [3:0] v);
    sck_i = 1'b0;
    waitn(8);
    chk(tag, {28'd0, io_o}, {28'd0, v});
    sck_i = 1'b1;
    waitn(8);
  endtask

  task automatic set_cfg(input logic [7:0] bc, input logic dir, input logic [31:0] d);
    txnbc_i   = bc;
    txndir_i  = dir;
    txndata_i = d;
  endtask

  task automatic end_ce();
    sck_i = 1'b0;
    waitn(8);
    ce_ni = 1'b1;
    waitn(8);
  endtask

  int d0, oe0;
  logic [39:0] exp40;

  initial begin
    // Reset state
    waitn(3);
    chk("rst_oe", {31'd0, io_oe_o}, 32'd0);
    chk("rst_io", {28'd0, io_o}, 32'd0);
    chk("rst_done", {31'd0, txndone_o}, 32'd0);
    chk("rst_data", txndata_o, 32'd0);
    chk("rst_txnreset", {31'd0, txnreset_o}, 32'd1);
    reset_ni = 1'b1;
    waitn(4);

    // RX 8 bits: A then 5
    d0 = done_cnt; oe0 = oe_hi_cnt;
    set_cfg(8'd8, 1'b0, 32'h0);
    ce_ni = 1'b0;
    rx_nib(4'hA); rx_nib(4'h5);
    chk("rx8_done", done_cnt - d0, 1);
    chk("rx8_data", txndata_o, 32'h000000A5);
    chk("rx8_oe", oe_hi_cnt - oe0, 0);
    end_ce();
    chk("rx8_txnreset", {31'd0, txnreset_o}, 32'd1);

    // Command (8 bits) then address (24 bits)
    d0 = done_cnt;
    set_cfg(8'd8, 1'b0, 32'h0);
    ce_ni = 1'b0;
    rx_nib(4'h0); rx_nib(4'hB);
    chk("cmd_done", done_cnt - d0, 1);
    chk("cmd_data", txndata_o, 32'h0000000B);
    set_cfg(8'd24, 1'b0, 32'h0);
    for (int k = 1; k <= 6; k++) rx_nib(4'(k));
    chk("addr_done", done_cnt - d0, 2);
    chk("addr_data", txndata_o, 32'h00123456);
    end_ce();

    // TX 16 bits twice, output enable held across the words
    d0 = done_cnt;
    set_cfg(8'd16, 1'b1, 32'h0000BEEF);
    ce_ni = 1'b0;
    tx_nib("tx_b", 4'hB); tx_nib("tx_e1", 4'hE); tx_nib("tx_e2", 4'hE); tx_nib("tx_f", 4'hF);
    chk("tx1_done", done_cnt - d0, 1);
    set_cfg(8'd16, 1'b1, 32'h00001234);
    tx_nib("tx_1", 4'h1);
    chk("tx2_oe", {31'd0, io_oe_o}, 32'd1);
    tx_nib("tx_2", 4'h2); tx_nib("tx_3", 4'h3); tx_nib("tx_4", 4'h4);
    chk("tx2_done", done_cnt - d0, 2);
    chk("tx_keeps_data", txndata_o, 32'h00123456);
    end_ce();
    chk("tx_end_oe", {31'd0, io_oe_o}, 32'd0);
    chk("tx_end_io", {28'd0, io_o}, 32'd0);

    // RX abort after 3 of 6 nibbles
    d0 = done_cnt;
    set_cfg(8'd24, 1'b0, 32'h0);
    ce_ni = 1'b0;
    rx_nib(4'h9); rx_nib(4'h8); rx_nib(4'h7);
    sck_i = 1'b0;
    ce_ni = 1'b1;
    waitn(4);
    chk("abort_txnreset", {31'd0, txnreset_o}, 32'd1);
    chk("abort_oe", {31'd0, io_oe_o}, 32'd0);
    waitn(8);
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_data", txndata_o, 32'h00123456);

    // TX abort: output enable must drop promptly
    set_cfg(8'd16, 1'b1, 32'h0000CAFE);
    ce_ni = 1'b0;
    tx_nib("txab_c", 4'hC); tx_nib("txab_a", 4'hA);
    sck_i = 1'b0;
    ce_ni = 1'b1;
    waitn(4);
    chk("txab_oe", {31'd0, io_oe_o}, 32'd0);
    chk("txab_io", {28'd0, io_o}, 32'd0);
    waitn(8);

    // TX 40 bits from a 32-bit word: top nibbles read as zero
    d0 = done_cnt;
    set_cfg(8'd40, 1'b1, 32'h89ABCDEF);
    exp40 = 40'h0089ABCDEF;
    ce_ni = 1'b0;
    for (int k = 0; k < 10; k++) tx_nib("tx40_nib", exp40[39-4*k -: 4]);
    chk("tx40_done", done_cnt - d0, 1);
    // bc=0 -> one nibble
    set_cfg(8'd0, 1'b1, 32'h0000000C);
    tx_nib("bc0_nib", 4'hC);
    chk("bc0_done", done_cnt - d0, 2);
    // bc=6 RX -> two nibbles; output enable drops at its config sample
    set_cfg(8'd6, 1'b0, 32'h0);
    sck_i = 1'b0;
    waitn(8);
    chk("bc6_oe", {31'd0, io_oe_o}, 32'd0);
    chk("bc6_io", {28'd0, io_o}, 32'd0);
    rx_nib(4'h3);
    chk("bc6_mid_done", done_cnt - d0, 2);
    rx_nib(4'h7);
    chk("bc6_done", done_cnt - d0, 3);
    chk("bc6_data", txndata_o, 32'h00000037);
    end_ce();

    // Reset asserted mid-TX
    set_cfg(8'd16, 1'b1, 32'h0000BEEF);
    ce_ni = 1'b0;
    tx_nib("rtx_b", 4'hB);
    sck_i = 1'b0;
    waitn(8);
    chk("rtx_e", {28'd0, io_o}, 32'hE);
    reset_ni = 1'b0;
    #1;
    chk("rtx_oe", {31'd0, io_oe_o}, 32'd0);
    chk("rtx_io", {28'd0, io_o}, 32'd0);
    chk("rtx_done", {31'd0, txndone_o}, 32'd0);
    chk("rtx_data", txndata_o, 32'd0);
    chk("rtx_txnreset", {31'd0, txnreset_o}, 32'd1);
    ce_ni = 1'b1;
    waitn(4);
    reset_ni = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) rx_nib(4'hF);
    sck_i = 1'b0;
    waitn(8);
    chk("rel_done", done_cnt - d0, 0);
    chk("rel_data", txndata_o, 32'd0);

    chk("done_width", wide_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
